rt_scan_controller: RTL and testbench

RT_SCAN_CONTROLLER -- requirements
Module: rt_scan_controller

---
 rtl/rt_scan_controller_if.sv | 31 +++
 rtl/rt_scan_controller.sv | 158 +++++++++++++++
 tb/tb_rt_scan_controller.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rt_scan_controller_if.sv
// Handshake bundle between the scan controller, the ray-trace core and the framebuffer.
// master = controller side, slave = environment (core, framebuffer, host) side.
interface rt_scan_controller_if;
  logic        START;
  logic        ABORT;
  logic        CORE_ENABLE;
  logic [9:0]  CORE_X;
  logic [8:0]  CORE_Y;
  logic        CORE_READY;
  logic [3:0]  CORE_PIXEL;
  logic        FB_WE;
  logic [18:0] FB_ADDR;
  logic [3:0]  FB_DATA;
  logic        FB_READY;
  logic        BUSY;
  logic        FRAME_DONE;
  logic [7:0]  FRAME_COUNT;
  logic        ERR;

  modport master (
    input  START, ABORT, CORE_READY, CORE_PIXEL, FB_READY,
    output CORE_ENABLE, CORE_X, CORE_Y, FB_WE, FB_ADDR, FB_DATA,
           BUSY, FRAME_DONE, FRAME_COUNT, ERR
  );

  modport slave (
    output START, ABORT, CORE_READY, CORE_PIXEL, FB_READY,
    input  CORE_ENABLE, CORE_X, CORE_Y, FB_WE, FB_ADDR, FB_DATA,
           BUSY, FRAME_DONE, FRAME_COUNT, ERR
  );
endinterface

// File: rtl/rt_scan_controller.sv
// Raster-scan sequencer: issues one ray-trace request per pixel, waits for the
// result (with a per-pixel watchdog) and writes it to the framebuffer.
module rt_scan_controller #(
  parameter int unsigned H_RES          = 640,
  parameter int unsigned V_RES          = 480,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic               CLK,
  input logic               RESET,
  rt_scan_controller_if.master bus
);

  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned PIX_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WD_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_RES - 1);
  localparam logic [ADDR_W-1:0] H_RES_A   = ADDR_W'(H_RES);
  localparam logic [PIX_W-1:0]  PIX_ERROR = PIX_W'(4'hF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_core_enable;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic                r_fb_we;
  logic [ADDR_W-1:0]   r_fb_addr;
  logic [PIX_W-1:0]    r_fb_data;
  logic                r_busy;
  logic                r_frame_done;
  logic [CNT_W-1:0]    r_frame_count;
  logic                r_err;
  logic [WD_W-1:0]     r_wd;

  logic [ADDR_W-1:0]   w_addr;
  logic                w_last_pixel;

  assign w_addr       = (ADDR_W'(r_y) * H_RES_A) + ADDR_W'(r_x);
  assign w_last_pixel = (r_x == X_LAST) && (r_y == Y_LAST);

  // Single registered FSM; every output below is a flop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_core_enable <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_fb_we       <= 1'b0;
      r_fb_addr     <= '0;
      r_fb_data     <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_err         <= 1'b0;
      r_wd          <= '0;
    end else begin
      r_core_enable <= 1'b0;
      r_frame_done  <= 1'b0;

      if ((r_state != S_IDLE) && bus.ABORT) begin
        r_state <= S_IDLE;
        r_fb_we <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.START) begin
              r_state       <= S_ISSUE;
              r_x           <= '0;
              r_y           <= '0;
              r_err         <= 1'b0;
              r_busy        <= 1'b1;
              r_core_enable <= 1'b1;
            end
          end

          S_ISSUE: begin
            r_wd    <= '0;
            r_state <= S_WAIT;
          end

          // A result arriving on the expiry cycle beats the watchdog.
          S_WAIT: begin
            if (bus.CORE_READY) begin
              r_fb_data <= bus.CORE_PIXEL;
              r_fb_addr <= w_addr;
              r_fb_we   <= 1'b1;
              r_state   <= S_WRITE;
            end else if (r_wd == WD_LAST) begin
              r_fb_data <= PIX_ERROR;
              r_fb_addr <= w_addr;
              r_fb_we   <= 1'b1;
              r_err     <= 1'b1;
              r_state   <= S_WRITE;
            end else begin
              r_wd <= r_wd + WD_W'(1);
            end
          end

          S_WRITE: begin
            if (bus.FB_READY) begin
              r_fb_we <= 1'b0;
              if (w_last_pixel) begin
                r_state       <= S_DONE;
                r_frame_done  <= 1'b1;
                r_frame_count <= r_frame_count + CNT_W'(1);
              end else begin
                r_state       <= S_ISSUE;
                r_core_enable <= 1'b1;
                if (r_x == X_LAST) begin
                  r_x <= '0;
                  r_y <= r_y + Y_W'(1);
                end else begin
                  r_x <= r_x + X_W'(1);
                end
              end
            end
          end

          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_fb_we <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.CORE_ENABLE = r_core_enable;
  assign bus.CORE_X      = r_x;
  assign bus.CORE_Y      = r_y;
  assign bus.FB_WE       = r_fb_we;
  assign bus.FB_ADDR     = r_fb_addr;
  assign bus.FB_DATA     = r_fb_data;
  assign bus.BUSY        = r_busy;
  assign bus.FRAME_DONE  = r_frame_done;
  assign bus.FRAME_COUNT = r_frame_count;
  assign bus.ERR         = r_err;

endmodule

// File: tb/tb_rt_scan_controller.sv
// Bench for rt_scan_controller on a 4x2 frame: core/framebuffer models plus a
// write scoreboard fed at frame start and drained on every accepted write.
module tb_rt_scan_controller;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;
  localparam int unsigned TO = 8;

  typedef struct packed {
    logic [18:0] addr;
    logic [3:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rt_scan_controller_if bus();

  rt_scan_controller #(.H_RES(H), .V_RES(V), .TIMEOUT_CYCLES(TO)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         n_checks    = 0;
  int         n_fail      = 0;
  int         n_enable    = 0;
  int         n_done      = 0;
  int         en_during_we = 0;
  int         core_cnt    = 0;
  logic [3:0] core_pix    = 4'd0;
  bit         silent_en   = 1'b0;
  int         silent_x    = 0;
  int         silent_y    = 0;
  bit         fb_hold     = 1'b0;
  int         stall_addr  = -1;
  int         stall_left  = 0;
  int         stall_we    = 0;
  bit         stall_seen  = 1'b0;
  logic [3:0] stall_data  = 4'd0;

  // Core replies two cycles after each request; framebuffer accepts unless stalled.
  always @(posedge clk) begin
    #1;
    if (core_cnt == 1) begin
      bus.CORE_READY = 1'b1;
      bus.CORE_PIXEL = core_pix;
    end else begin
      bus.CORE_READY = 1'b0;
      bus.CORE_PIXEL = 4'd0;
    end
    if (core_cnt > 0) core_cnt--;
    if (bus.CORE_ENABLE) begin
      n_enable++;
      if (!(silent_en && int'(bus.CORE_X) == silent_x && int'(bus.CORE_Y) == silent_y)) begin
        core_cnt = 2;
        core_pix = 4'(bus.CORE_X + 10'(bus.CORE_Y));
      end
    end
    if (bus.FRAME_DONE) n_done++;
    if (bus.FB_WE) begin
      n_checks++;
      if (bus.FB_ADDR !== (19'(bus.CORE_Y) * 19'(H) + 19'(bus.CORE_X))) begin
        n_fail++;
        $display("FAIL addr_vs_xy: FB_ADDR=%0d, required %0d", bus.FB_ADDR,
                 19'(bus.CORE_Y) * 19'(H) + 19'(bus.CORE_X));
      end
      if (bus.CORE_ENABLE) en_during_we++;
      if (int'(bus.FB_ADDR) == stall_addr) begin
        stall_we++;
        if (!stall_seen) begin
          stall_seen = 1'b1;
          stall_data = bus.FB_DATA;
        end else begin
          n_checks++;
          if (bus.FB_DATA !== stall_data) begin
            n_fail++;
            $display("FAIL stall_data_stable: FB_DATA=%0h, required %0h", bus.FB_DATA, stall_data);
          end
        end
      end
      if (fb_hold) begin
        bus.FB_READY = 1'b0;
      end else if (int'(bus.FB_ADDR) == stall_addr && stall_left > 0) begin
        bus.FB_READY = 1'b0;
        stall_left--;
      end else begin
        bus.FB_READY = 1'b1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: addr=%0d data=%0h, required no write", bus.FB_ADDR, bus.FB_DATA);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.FB_ADDR, bus.FB_DATA} !== {mon_e.addr, mon_e.data}) begin
            n_fail++;
            $display("FAIL wr_scoreboard: addr=%0d data=%0h, required addr=%0d data=%0h",
                     bus.FB_ADDR, bus.FB_DATA, mon_e.addr, mon_e.data);
          end
        end
      end
    end else begin
      bus.FB_READY = !fb_hold;
    end
  end

  task automatic push_frame();
    for (int y = 0; y < int'(V); y++) begin
      for (int x = 0; x < int'(H); x++) begin
        wr_t w;
        w.addr = 19'(y * int'(H) + x);
        w.data = (silent_en && x == silent_x && y == silent_y) ? 4'hF : 4'(x + y);
        exp_q.push_back(w);
      end
    end
  endtask

  // Pulses START for one sampling edge; returns at #1 into the following cycle.
  task automatic pulse_start();
    bus.START = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (bus.FRAME_DONE) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.CORE_ENABLE, bus.CORE_X, bus.CORE_Y, bus.FB_WE, bus.FB_ADDR, bus.FB_DATA,
         bus.BUSY, bus.FRAME_DONE, bus.FRAME_COUNT, bus.ERR} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: BUSY=%b FB_WE=%b FRAME_COUNT=%0d ERR=%b, required all zero",
               bus.BUSY, bus.FB_WE, bus.FRAME_COUNT, bus.ERR);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.BUSY !== 1'b0 || bus.CORE_ENABLE !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: BUSY=%b CORE_ENABLE=%b, required 0 0", bus.BUSY, bus.CORE_ENABLE);
    end
  endtask

  task automatic test_frame();
    int en0 = n_enable;
    int d0  = n_done;
    bit ok;
    push_frame();
    pulse_start();
    n_checks++;
    if (bus.CORE_ENABLE !== 1'b1 || bus.BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: CORE_ENABLE=%b BUSY=%b, required 1 1", bus.CORE_ENABLE, bus.BUSY);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.CORE_ENABLE !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_one_cycle: CORE_ENABLE=%b, required 0", bus.CORE_ENABLE);
    end
    wait_done(200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL frame_done_timeout: FRAME_DONE=0, required 1 within 200 cycles");
    end
    n_checks++;
    if (bus.FRAME_COUNT !== 8'd1) begin
      n_fail++;
      $display("FAIL frame_count_1: FRAME_COUNT=%0d, required 1", bus.FRAME_COUNT);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.BUSY !== 1'b0 || bus.FRAME_DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end_idle: BUSY=%b FRAME_DONE=%b, required 0 0", bus.BUSY, bus.FRAME_DONE);
    end
    n_checks++;
    if (exp_q.size() != 0 || n_enable - en0 != 8 || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL frame_totals: left=%0d enables=%0d dones=%0d, required 0 8 1",
               exp_q.size(), n_enable - en0, n_done - d0);
    end
  endtask

  task automatic test_fb_stall();
    bit ok;
    stall_addr   = 5;
    stall_left   = 5;
    stall_we     = 0;
    stall_seen   = 1'b0;
    en_during_we = 0;
    push_frame();
    pulse_start();
    wait_done(300, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_frame_done: FRAME_DONE=0, required 1 within 300 cycles");
    end
    n_checks++;
    if (stall_we != 6) begin
      n_fail++;
      $display("FAIL stall_we_cycles: FB_WE cycles at addr 5=%0d, required 6", stall_we);
    end
    n_checks++;
    if (stall_data !== 4'd2) begin
      n_fail++;
      $display("FAIL stall_data_value: FB_DATA=%0h, required 2", stall_data);
    end
    n_checks++;
    if (en_during_we != 0) begin
      n_fail++;
      $display("FAIL stall_no_enable: CORE_ENABLE during FB_WE=%0d, required 0", en_during_we);
    end
    n_checks++;
    if (bus.FRAME_COUNT !== 8'd2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_totals: FRAME_COUNT=%0d left=%0d, required 2 0", bus.FRAME_COUNT, exp_q.size());
    end
    stall_addr = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    bit ok;
    silent_en = 1'b1;
    silent_x  = 2;
    silent_y  = 0;
    push_frame();
    pulse_start();
    wait_done(400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_frame_done: FRAME_DONE=0, required 1 within 400 cycles");
    end
    n_checks++;
    if (bus.ERR !== 1'b1 || bus.FRAME_COUNT !== 8'd3) begin
      n_fail++;
      $display("FAIL timeout_err: ERR=%b FRAME_COUNT=%0d, required 1 3", bus.ERR, bus.FRAME_COUNT);
    end
    silent_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.ERR !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_err_sticky: ERR=%b left=%0d, required 1 0", bus.ERR, exp_q.size());
    end
  endtask

  task automatic test_abort();
    bit ok;
    bit found = 1'b0;
    int d0;
    push_frame();
    pulse_start();
    n_checks++;
    if (bus.ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear_on_start: ERR=%b, required 0", bus.ERR);
    end
    for (int i = 0; i < 100; i++) begin
      if (bus.CORE_ENABLE && bus.CORE_X == 10'd1 && bus.CORE_Y == 9'd1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL abort_reach_pixel: request (1,1) not seen, required within 100 cycles");
    end
    @(posedge clk); #1;
    bus.ABORT = 1'b1;
    d0 = n_done;
    @(posedge clk); #1;
    bus.ABORT = 1'b0;
    n_checks++;
    if (bus.BUSY !== 1'b0 || bus.FB_WE !== 1'b0 || bus.CORE_ENABLE !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: BUSY=%b FB_WE=%b CORE_ENABLE=%b, required 0 0 0",
               bus.BUSY, bus.FB_WE, bus.CORE_ENABLE);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (n_done != d0 || bus.FRAME_COUNT !== 8'd3 || exp_q.size() != 3) begin
      n_fail++;
      $display("FAIL abort_totals: dones=%0d FRAME_COUNT=%0d left=%0d, required 0 3 3",
               n_done - d0, bus.FRAME_COUNT, exp_q.size());
    end
    exp_q.delete();
    // START and ABORT together in IDLE: START wins.
    push_frame();
    bus.ABORT = 1'b1;
    pulse_start();
    bus.ABORT = 1'b0;
    n_checks++;
    if (bus.CORE_ENABLE !== 1'b1 || bus.CORE_X !== 10'd0 || bus.CORE_Y !== 9'd0) begin
      n_fail++;
      $display("FAIL restart_origin: CORE_ENABLE=%b X=%0d Y=%0d, required 1 0 0",
               bus.CORE_ENABLE, bus.CORE_X, bus.CORE_Y);
    end
    wait_done(200, ok);
    n_checks++;
    if (!ok || bus.FRAME_COUNT !== 8'd4 || bus.ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_frame: done=%b FRAME_COUNT=%0d ERR=%b, required 1 4 0",
               ok, bus.FRAME_COUNT, bus.ERR);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int d0 = n_done;
    fb_hold = 1'b1;
    push_frame();
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (bus.FB_WE) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_reach_write: FB_WE=0, required 1 within 50 cycles");
    end
    rst       = 1'b1;
    bus.START = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.CORE_ENABLE, bus.CORE_X, bus.CORE_Y, bus.FB_WE, bus.FB_ADDR, bus.FB_DATA,
         bus.BUSY, bus.FRAME_DONE, bus.FRAME_COUNT, bus.ERR} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: FB_WE=%b BUSY=%b FRAME_COUNT=%0d, required all zero",
               bus.FB_WE, bus.BUSY, bus.FRAME_COUNT);
    end
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.START = 1'b0;
    fb_hold   = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.BUSY !== 1'b0 || bus.CORE_ENABLE !== 1'b0 || n_done != d0 || exp_q.size() != 8) begin
      n_fail++;
      $display("FAIL reset_mid_discard: BUSY=%b CORE_ENABLE=%b dones=%0d left=%0d, required 0 0 0 8",
               bus.BUSY, bus.CORE_ENABLE, n_done - d0, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int en0 = n_enable;
    int d0  = n_done;
    for (int f = 0; f < 256; f++) begin
      bit ok = 1'b0;
      push_frame();
      pulse_start();
      for (int k = 0; k < 200; k++) begin
        bus.START = (k >= 5 && k < 8);
        @(posedge clk); #1;
        if (bus.FRAME_DONE) begin
          ok = 1'b1;
          break;
        end
      end
      bus.START = 1'b0;
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL b2b_frame_done: frame %0d FRAME_DONE=0, required 1 within 200 cycles", f);
        break;
      end
      if (f == 254) begin
        n_checks++;
        if (bus.FRAME_COUNT !== 8'd255) begin
          n_fail++;
          $display("FAIL b2b_count_255: FRAME_COUNT=%0d, required 255", bus.FRAME_COUNT);
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.FRAME_COUNT !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_count_wrap: FRAME_COUNT=%0d, required 0", bus.FRAME_COUNT);
    end
    n_checks++;
    if (n_enable - en0 != 2048 || n_done - d0 != 256 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_totals: enables=%0d dones=%0d left=%0d, required 2048 256 0",
               n_enable - en0, n_done - d0, exp_q.size());
    end
  endtask

  initial begin
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    test_reset();
    test_frame();
    test_fb_stall();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
